// File: rtl/pipeline_exmem_skid.sv
// pipeline_exmem_skid: EX/MEM stage register with valid/ready handshake and one-entry skid buffer
//   in_valid/in_ready/flush : EX-side handshake; flush drops held and incoming instructions
//   *_in                    : wb control, {MemWrite,MemRead}, flags, ALU result, store data, dest reg
//   out_valid/out_ready     : MEM-side handshake; outputs come straight from the main entry
//   mem_write/mem_read/wb_out : control outputs, forced to 0 while out_valid is low
//   occupancy               : number of valid entries (0..2)
module pipeline_exmem_skid #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int WB_W   = 4,
   parameter int FLAG_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [WB_W-1:0]   wb_in,
   input  logic [1:0]        mem_in,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [DATA_W-1:0] rt_in,
   input  logic [REG_W-1:0]  dst_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              mem_write,
   output logic              mem_read,
   output logic [WB_W-1:0]   wb_out,
   output logic [FLAG_W-1:0] flags_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] rt_out,
   output logic [REG_W-1:0]  dst_out,
   output logic [1:0]        occupancy
);
   localparam int E_W = WB_W + 2 + FLAG_W + 2 * DATA_W + REG_W;
   logic main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic [E_W-1:0] main_q, main_d, skid_q, skid_d, in_e;
   logic in_fire, out_fire, ld_main;
   logic [WB_W-1:0] wb_m;
   logic [1:0] mem_m;
   assign in_e      = {wb_in, mem_in, flags_in, alu_in, rt_in, dst_in};
   assign in_ready  = !skid_v_q;
   assign out_valid = main_v_q;
   assign in_fire   = in_valid & in_ready & !flush;
   assign out_fire  = main_v_q & out_ready;
   // main reloads when empty or draining; the older skid entry always wins over the input
   assign ld_main   = !flush & (out_fire | !main_v_q);
   always_comb begin
      main_d   = ld_main ? (skid_v_q ? skid_q : (in_fire ? in_e : main_q)) : main_q;
      skid_d   = (in_fire & main_v_q & !out_fire) ? in_e : skid_q;
      main_v_d = !flush & (skid_v_q | in_fire | (main_v_q & !out_fire));
      skid_v_d = !flush & (skid_v_q ? !out_fire : (in_fire & main_v_q & !out_fire));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
      end
   end
   assign {wb_m, mem_m, flags_out, alu_out, rt_out, dst_out} = main_q;
   assign wb_out    = out_valid ? wb_m : '0;
   assign mem_write = out_valid & mem_m[1];
   assign mem_read  = out_valid & mem_m[0];
   assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
endmodule

// File: doc/pipeline_exmem_skid.md
# pipeline_exmem_skid

Parametrised EX/MEM pipeline register with a valid/ready handshake and a one-entry skid buffer. It sits between the execute stage and the memory stage. It carries write-back control, memory control, ALU flags, ALU result, store data (rt) and destination register. Unlike a plain always-enabled stage register, it supports downstream back-pressure (for example, a multi-cycle data memory), flush and bubble insertion, and it exports forwarding information for the hazard unit.

## Interface
Parameters:
- DATA_W, 16, width of the ALU result and store-data fields
- REG_W, 4, width of the destination-register field
- WB_W, 4, width of the write-back control bundle
- FLAG_W, 3, width of the ALU flags field

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  EX stage presents a valid instruction
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- flush  input  1  discard all held and incoming instructions this cycle
- wb_in  input  WB_W  write-back control bundle
- mem_in  input  2  {MemWrite, MemRead}
- flags_in  input  FLAG_W  ALU flags
- alu_in  input  DATA_W  ALU result / address
- rt_in  input  DATA_W  store data
- dst_in  input  REG_W  destination register
- out_valid  output  1  main entry holds a valid instruction
- out_ready  input  1  MEM stage consumes the main entry this cycle
- mem_write, mem_read  output  1 each  memory control, gated by out_valid
- wb_out  output  WB_W  write-back control, gated by out_valid
- flags_out  output  FLAG_W  flags of the main entry
- alu_out, rt_out  output  DATA_W  data fields of the main entry
- dst_out  output  REG_W  destination register of the main entry
- occupancy  output  2  number of valid entries: 0, 1 or 2

## Operation
- Storage consists of a main entry (drives the outputs) and a skid entry. Each has a valid bit and a full copy of all fields.
- Handshakes:
  - in_fire = in_valid & in_ready & !flush
  - out_fire = out_valid & out_ready
- States are encoded by {skid_valid, main_valid}:
  - EMPTY (00):
    - in_fire: main <= input, go to ONE.
  - ONE (01):
    - in_fire & out_fire: main <= input, stay in ONE.
    - out_fire only: go to EMPTY.
    - in_fire only: skid <= input, go to FULL.
    - neither: hold.
  - FULL (11):
    - in_ready = 0.
    - out_fire: main <= skid, skid invalid, go to ONE.
    - otherwise: hold.
- State 10 is unreachable and must never occur.
- Ordering is strict FIFO. The skid entry is always younger than the main entry.
- Bubble gating: mem_write, mem_read and wb_out are forced to 0 whenever out_valid = 0. Data outputs (alu_out, rt_out, dst_out, flags_out) hold their last loaded value and are don't-care while invalid.
- Flush:
  - Both valid bits are cleared on the next edge.
  - The incoming transfer is dropped, even if in_valid = 1.
  - Data registers are not cleared.
  - Flush has priority over all handshake activity and over out_fire.
- Reset:
  - All valid bits and all data fields go to 0.
  - Outputs after reset: out_valid = 0, in_ready = 1, occupancy = 0, all control and data outputs = 0.
  - Reset overrides flush and every handshake, including when asserted mid-stall in FULL.
- occupancy = main_valid + skid_valid.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs after edge N when the stage was EMPTY or ONE-with-out_fire. This gives 1 cycle of latency with no bubbles at full throughput.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.
- Output fields are driven directly from main-entry registers (combinational gating only by out_valid).
- A transfer on the input is allowed in the same cycle as out_fire in ONE. Sustained throughput is 1 instruction per cycle.
- In FULL, one out_fire returns the stage to ONE. in_ready rises in the cycle after that edge.

## Test plan
- Streaming: after reset, drive in_valid = 1 with alu_in = 0x0001 through 0x0008 on consecutive cycles, out_ready = 1. Required response: out_valid rises one cycle after the first transfer, outputs 0x0001 through 0x0008 appear on consecutive cycles, and in_ready stays 1.
- Skid:
  - Send A = 0x1111, then B = 0x2222, with out_ready = 0. Required: occupancy = 2, in_ready = 0, and alu_out holds 0x1111.
  - Raise out_ready for 1 cycle. Required: alu_out = 0x2222, occupancy = 1, in_ready = 1.
- Random back-pressure: toggle out_ready pseudo-randomly over 200 transfers with incrementing alu_in. Required: the output sequence is complete, in order and without duplicates, and occupancy never exceeds 2.
- Flush in FULL: fill both entries, then assert flush together with in_valid = 1 and mem_in = 2'b10. Required, next cycle: out_valid = 0, mem_write = 0, occupancy = 0, and the flushed input never appears.
- Bubble gating: load an entry with wb_in = 4'hF and mem_in = 2'b11, then drain it with no new input. Required: wb_out = 0, mem_write = 0 and mem_read = 0 while out_valid = 0.
- Reset mid-stall: in FULL with out_ready = 0, assert rst for 1 cycle. Required: all outputs are 0, in_ready = 1, occupancy = 0, and both previous entries are lost.
